// File: rtl/eeprom_slave.sv
// eeprom_slave: I2C-style serial EEPROM slave, 2^ADDR_W bytes.
// Decodes start/stop, control/address/data bytes, drives ACK and read data.
`timescale 1ns/1ps
module eeprom_slave #(
    parameter logic [3:0] DEV_ID = 4'b1010,
    parameter int         ADDR_W = 11
) (
    input  logic CLK,
    input  logic RESET,
    input  logic SCL,
    inout  wire  SDA,
    output logic BUSY,
    output logic WR_DONE
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CTRL,
        S_CTRL_ACK,
        S_ADDR,
        S_ADDR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RACK,
        S_WAIT_STOP
    } state_t;

    state_t state, state_n;

    logic scl_s1, scl_s2, scl_q;
    logic sda_s1, sda_s2, sda_q;
    logic start_ev, stop_ev, scl_rise, scl_fall;

    logic [2:0]        cnt, cnt_n;
    logic [7:0]        sr, sr_n;
    logic [7:0]        byte_in, rd_byte;
    logic [ADDR_W-1:0] addr, addr_n;
    logic              oe, oe_n;
    logic              sda_o, sda_o_n;
    logic              ack_ph, ack_ph_n;
    logic              rw, rw_n;
    logic              commit, commit_n;

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    // Two-flop synchronizers plus one edge-history register per pin.
    // Idle bus is high, so reset to 1 to avoid a phantom start on release.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_q  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_q  <= 1'b1;
        end else begin
            scl_s1 <= SCL;
            scl_s2 <= scl_s1;
            scl_q  <= scl_s2;
            sda_s1 <= SDA;
            sda_s2 <= sda_s1;
            sda_q  <= sda_s2;
        end
    end

    assign start_ev = scl_s2 & sda_q & ~sda_s2;
    assign stop_ev  = scl_s2 & ~sda_q & sda_s2;
    assign scl_rise = scl_s2 & ~scl_q;
    assign scl_fall = ~scl_s2 & scl_q;

    assign byte_in = {sr[6:0], sda_s2};
    assign rd_byte = mem[addr];

    assign SDA  = oe ? sda_o : 1'bz;
    assign BUSY = (state != S_IDLE);

    // Byte store; commit fires one cycle after the 8th data sample.
    always_ff @(posedge CLK) begin
        if (commit) begin
            mem[addr] <= sr;
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= S_IDLE;
            cnt     <= 3'd0;
            sr      <= 8'd0;
            addr    <= '0;
            oe      <= 1'b0;
            sda_o   <= 1'b0;
            ack_ph  <= 1'b0;
            rw      <= 1'b0;
            commit  <= 1'b0;
            WR_DONE <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            sr      <= sr_n;
            addr    <= addr_n;
            oe      <= oe_n;
            sda_o   <= sda_o_n;
            ack_ph  <= ack_ph_n;
            rw      <= rw_n;
            commit  <= commit_n;
            WR_DONE <= commit;
        end
    end

    // Next-state and datapath logic; start/stop override any SCL edge.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sr_n     = sr;
        addr_n   = addr;
        oe_n     = oe;
        sda_o_n  = sda_o;
        ack_ph_n = ack_ph;
        rw_n     = rw;
        commit_n = 1'b0;

        if (commit) begin
            addr_n = addr + ADDR_W'(1);
        end

        if (start_ev) begin
            state_n  = S_CTRL;
            cnt_n    = 3'd0;
            oe_n     = 1'b0;
            ack_ph_n = 1'b0;
        end else if (stop_ev) begin
            state_n  = S_IDLE;
            cnt_n    = 3'd0;
            oe_n     = 1'b0;
            ack_ph_n = 1'b0;
        end else begin
            unique case (state)
                S_CTRL: begin
                    if (scl_rise) begin
                        sr_n  = byte_in;
                        cnt_n = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            if (byte_in[7:4] == DEV_ID) begin
                                state_n  = S_CTRL_ACK;
                                rw_n     = byte_in[0];
                                ack_ph_n = 1'b0;
                                addr_n[ADDR_W-1:8] = byte_in[ADDR_W-8:1];
                            end else begin
                                state_n = S_IDLE;
                            end
                        end
                    end
                end
                S_ADDR: begin
                    if (scl_rise) begin
                        sr_n  = byte_in;
                        cnt_n = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            addr_n[7:0] = byte_in;
                            state_n     = S_ADDR_ACK;
                            ack_ph_n    = 1'b0;
                        end
                    end
                end
                S_WDATA: begin
                    if (scl_rise) begin
                        sr_n  = byte_in;
                        cnt_n = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            commit_n = 1'b1;
                            state_n  = S_WDATA_ACK;
                            ack_ph_n = 1'b0;
                        end
                    end
                end
                S_CTRL_ACK, S_ADDR_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_ph) begin
                            oe_n     = 1'b1;
                            sda_o_n  = 1'b0;
                            ack_ph_n = 1'b1;
                        end else begin
                            ack_ph_n = 1'b0;
                            cnt_n    = 3'd0;
                            oe_n     = 1'b0;
                            if (state == S_CTRL_ACK && rw) begin
                                state_n = S_RDATA;
                                sr_n    = rd_byte;
                                sda_o_n = rd_byte[7];
                                oe_n    = 1'b1;
                            end else if (state == S_CTRL_ACK) begin
                                state_n = S_ADDR;
                            end else begin
                                state_n = S_WDATA;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_fall) begin
                        if (cnt == 3'd7) begin
                            oe_n     = 1'b0;
                            addr_n   = addr + ADDR_W'(1);
                            cnt_n    = 3'd0;
                            ack_ph_n = 1'b0;
                            state_n  = S_RACK;
                        end else begin
                            sr_n    = {sr[6:0], 1'b0};
                            sda_o_n = sr[6];
                            cnt_n   = cnt + 3'd1;
                        end
                    end
                end
                S_RACK: begin
                    if (!ack_ph && scl_rise) begin
                        if (sda_s2) begin
                            state_n = S_WAIT_STOP;
                        end else begin
                            ack_ph_n = 1'b1;
                        end
                    end else if (ack_ph && scl_fall) begin
                        state_n  = S_RDATA;
                        ack_ph_n = 1'b0;
                        cnt_n    = 3'd0;
                        sr_n     = rd_byte;
                        sda_o_n  = rd_byte[7];
                        oe_n     = 1'b1;
                    end
                end
                S_IDLE, S_WAIT_STOP: begin
                    state_n = state;
                end
                default: begin
                    state_n = S_IDLE;
                    oe_n    = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eeprom_slave.sv
// tb_eeprom_slave: bit-level bus master driving eeprom_slave.
// Expected values queued at stimulus time, popped at observation.
`timescale 1ns/1ps
module tb_eeprom_slave;

    logic CLK = 1'b0;
    logic RESET;
    logic SCL;
    logic m_low;
    wire  SDA;
    logic BUSY;
    logic WR_DONE;

    assign SDA = m_low ? 1'b0 : 1'bz;
    pullup (SDA);

    eeprom_slave dut (
        .CLK(CLK),
        .RESET(RESET),
        .SCL(SCL),
        .SDA(SDA),
        .BUSY(BUSY),
        .WR_DONE(WR_DONE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    int rise_cyc = 0;
    int wr_cnt = 0;
    int wr_lat = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    // Count WR_DONE high cycles and latency from the last SCL rise.
    always @(negedge CLK) begin
        if (WR_DONE === 1'b1) begin
            wr_cnt <= wr_cnt + 1;
            wr_lat <= cyc - rise_cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [7:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %0h expected none", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp_v);
        push(tag, exp_v);
        pop_check(obs);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic bus_start();
        m_low = 1'b0;
        SCL   = 1'b1;
        tick(8);
        m_low = 1'b1;
        tick(8);
        SCL = 1'b0;
    endtask

    task automatic bus_rstart();
        tick(1);
        m_low = 1'b0;
        tick(7);
        SCL = 1'b1;
        tick(8);
        m_low = 1'b1;
        tick(8);
        SCL = 1'b0;
    endtask

    task automatic bus_stop();
        tick(1);
        m_low = 1'b1;
        tick(7);
        SCL = 1'b1;
        tick(8);
        m_low = 1'b0;
        tick(8);
    endtask

    // One SCL period starting just after a falling edge.
    // e2/e3: SDA 2 and 3 CLK after that fall; s: SDA mid-high.
    task automatic bus_bit(input logic drv, input logic b,
                           output logic e2, output logic e3,
                           output logic s);
        tick(1);
        m_low = 1'b0;
        tick(1);
        e2 = SDA;
        tick(1);
        e3 = SDA;
        tick(1);
        m_low = drv & ~b;
        tick(4);
        SCL = 1'b1;
        rise_cyc = cyc;
        tick(4);
        s = SDA;
        tick(4);
        SCL = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic a,
                             output logic ae2, output logic ae3,
                             output logic fe2, output logic fe3);
        logic d2, d3, s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, b[i], d2, d3, s);
            if (i == 7) begin
                fe2 = d2;
                fe3 = d3;
            end
        end
        bus_bit(1'b0, 1'b0, ae2, ae3, a);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d,
                             output logic a);
        logic d2, d3, s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b0, 1'b0, d2, d3, s);
            d[i] = s;
        end
        bus_bit(1'b1, nack, d2, d3, a);
    endtask

    task automatic send_chk(input string tag, input logic [7:0] b,
                            input logic exp_a);
        logic a, x2, x3, y2, y3;
        push(tag, {7'd0, exp_a});
        send_byte(b, a, x2, x3, y2, y3);
        pop_check({7'd0, a});
    endtask

    task automatic read_chk(input string tag, input logic nack,
                            input logic [7:0] exp_d);
        logic [7:0] d;
        logic a;
        push(tag, exp_d);
        push({tag, "_ackbit"}, {7'd0, nack});
        read_byte(nack, d, a);
        pop_check(d);
        pop_check({7'd0, a});
    endtask

    task automatic rand_read(input string tag, input logic [7:0] ctrl,
                             input logic [7:0] lo,
                             input logic [7:0] exp_d);
        bus_start();
        send_chk({tag, "_c"}, ctrl, 1'b0);
        send_chk({tag, "_a"}, lo, 1'b0);
        bus_rstart();
        send_chk({tag, "_r"}, ctrl | 8'h01, 1'b0);
        read_chk(tag, 1'b1, exp_d);
        bus_stop();
    endtask

    initial begin
        logic a, ae2, ae3, fe2, fe3;
        int w0;

        RESET = 1'b1;
        SCL   = 1'b1;
        m_low = 1'b0;
        tick(4);
        chk("rst_busy", {7'd0, BUSY}, 8'd0);
        chk("rst_wrdone", {7'd0, WR_DONE}, 8'd0);
        chk("rst_sda", {7'd0, SDA}, 8'd1);
        RESET = 1'b0;
        tick(10);

        // Single write with exact ACK timing
        w0 = wr_cnt;
        bus_start();
        chk("busy_start", {7'd0, BUSY}, 8'd1);
        push("ack_pre", 8'd1);
        push("ack_on", 8'd0);
        push("ctrl_ack", 8'd0);
        send_byte(8'hA0, a, ae2, ae3, fe2, fe3);
        pop_check({7'd0, ae2});
        pop_check({7'd0, ae3});
        pop_check({7'd0, a});
        push("ack_hold", 8'd0);
        push("ack_rel", 8'd1);
        push("addr_ack", 8'd0);
        send_byte(8'h35, a, ae2, ae3, fe2, fe3);
        pop_check({7'd0, fe2});
        pop_check({7'd0, fe3});
        pop_check({7'd0, a});
        send_chk("data_ack", 8'h5A, 1'b0);
        chk("wr_lat", 8'(wr_lat), 8'd4);
        bus_stop();
        chk("wr_cnt1", 8'(wr_cnt - w0), 8'd1);
        chk("busy_stop", {7'd0, BUSY}, 8'd0);
        rand_read("rd035", 8'hA0, 8'h35, 8'h5A);

        // Random read at 0x7F0
        bus_start();
        send_chk("w7f0_c", 8'hAE, 1'b0);
        send_chk("w7f0_a", 8'hF0, 1'b0);
        send_chk("w7f0_d", 8'hC3, 1'b0);
        bus_stop();
        rand_read("rd7f0", 8'hAE, 8'hF0, 8'hC3);

        // Sequential write/read across the wrap
        w0 = wr_cnt;
        bus_start();
        send_chk("w7ff_c", 8'hAE, 1'b0);
        send_chk("w7ff_a", 8'hFF, 1'b0);
        send_chk("w7ff_d0", 8'h11, 1'b0);
        send_chk("w7ff_d1", 8'h22, 1'b0);
        bus_stop();
        chk("wr_cnt2", 8'(wr_cnt - w0), 8'd2);
        bus_start();
        send_chk("r7ff_c", 8'hAE, 1'b0);
        send_chk("r7ff_a", 8'hFF, 1'b0);
        bus_rstart();
        send_chk("r7ff_r", 8'hAF, 1'b0);
        read_chk("seq0", 1'b0, 8'h11);
        read_chk("seq1", 1'b1, 8'h22);
        bus_stop();
        rand_read("rd000", 8'hA0, 8'h00, 8'h22);

        // Wrong device ID: bus ignored until next start
        w0 = wr_cnt;
        bus_start();
        send_chk("bad_id", 8'h90, 1'b1);
        chk("bad_busy", {7'd0, BUSY}, 8'd0);
        send_chk("ign_a", 8'h35, 1'b1);
        send_chk("ign_d", 8'hFF, 1'b1);
        bus_stop();
        chk("bad_wr", 8'(wr_cnt - w0), 8'd0);
        rand_read("rd035b", 8'hA0, 8'h35, 8'h5A);

        // Stop after 4 data bits
        w0 = wr_cnt;
        bus_start();
        send_chk("ab_c", 8'hA0, 1'b0);
        send_chk("ab_a", 8'h40, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bus_bit(1'b1, 1'b1, ae2, ae3, a);
        end
        bus_stop();
        chk("ab_wr", 8'(wr_cnt - w0), 8'd0);
        chk("ab_busy", {7'd0, BUSY}, 8'd0);

        // Reset while the slave drives a 0 read bit
        bus_start();
        send_chk("rr_c", 8'hA0, 1'b0);
        send_chk("rr_a", 8'h35, 1'b0);
        bus_rstart();
        send_chk("rr_r", 8'hA1, 1'b0);
        tick(6);
        chk("rr_drv", {7'd0, SDA}, 8'd0);
        RESET = 1'b1;
        #1;
        chk("rr_sda", {7'd0, SDA}, 8'd1);
        chk("rr_busy", {7'd0, BUSY}, 8'd0);
        tick(2);
        SCL = 1'b1;
        tick(2);
        RESET = 1'b0;
        tick(10);
        chk("rr_idle", {7'd0, BUSY}, 8'd0);

        // Current-address read from reset pointer 0x000
        bus_start();
        send_chk("cur_c", 8'hA1, 1'b0);
        read_chk("cur", 1'b1, 8'h22);
        bus_stop();
        rand_read("rd7f0b", 8'hAE, 8'hF0, 8'hC3);

        tick(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
